// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests bytes from program memory at pc, holds
// each fetched byte in the instruction register until the decode stage takes
// it, follows redirects, and stops for good on the halt opcode.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [7:0] instruction,
  output logic       inst_valid,
  input  logic       inst_ready,
  input  logic       jump_en,
  input  logic [7:0] jump_addr,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] instr_reg, instr_next;

  // State, program counter and instruction register; reset abandons any
  // in-flight fetch or held instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  // Next-state logic: a redirect wins over ack/ready in every live state,
  // while HALT is a sink that only reset leaves.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    if (jump_en && (state_reg != HALT)) begin
      // Any byte arriving or held this cycle is dropped.
      pc_next    = jump_addr;
      state_next = FETCH;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            instr_next = mem_data;
            pc_next    = pc_reg + 8'd1;  // wraps 8'hFF -> 8'h00
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state_next = (instr_reg[7:5] == HALT_OPCODE) ? HALT : FETCH;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs decode from the registered state only, so none of them depend
  // combinationally on the inputs.
  assign mem_req     = (state_reg == FETCH);
  assign inst_valid  = (state_reg == HOLD);
  assign halted      = (state_reg == HALT);
  assign mem_addr    = pc_reg;
  assign pc          = pc_reg;
  assign instruction = instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a randomized memory/decoder/redirect environment with
// a fetch-stream reference model and scoreboard, followed by directed
// scenarios for reset, stalls, redirects, halt and pc wraparound.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] instruction;
  logic       inst_valid;
  logic       inst_ready;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       halted;

  // Second instance with RESET_PC = 8'hFF for the wraparound case.
  logic       rst2_n;
  logic       mem_req2;
  logic [7:0] mem_addr2;
  logic [7:0] instruction2;
  logic       inst_valid2;
  logic [7:0] pc2;
  logic       halted2;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .instruction(instruction), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .pc(pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(8'hFF), .HALT_OPCODE(3'b111)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(1'b1), .mem_data(8'h12),
    .instruction(instruction2), .inst_valid(inst_valid2), .inst_ready(1'b1),
    .jump_en(1'b0), .jump_addr(8'h00),
    .pc(pc2), .halted(halted2)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem [256];
  logic       mon_en = 1'b0;
  logic       mon_prev_valid = 1'b0;
  exp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from the clock edge, holds it two cycles, checks the
  // reset values and releases it just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    jump_en = 1'b0; jump_addr = 8'h00; mem_ack = 1'b0; mem_data = 8'h00; inst_ready = 1'b0;
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_instruction", instruction, 8'h00);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: each new presentation of inst_valid must match the
  // oldest expected fetch, exactly one cycle after the ack that produced it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (inst_valid && !mon_prev_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: instruction 0x%0h presented, nothing expected (cycle %0d)",
                   instruction, cycle_cnt);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_instruction", instruction, mon_e.data);
          check("sb_pc", pc, mon_e.pc);
          check("sb_latency", cycle_cnt, mon_e.cyc + 1);
        end
      end
      if (sb_q.size() > 0 && cycle_cnt > sb_q[0].cyc + 1) begin
        mon_e = sb_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL sb_missing: got no presentation, expected instruction 0x%0h by cycle %0d",
                 mon_e.data, mon_e.cyc + 1);
      end
    end
    mon_prev_valid <= inst_valid;
  end

  logic [7:0] exp_addr;
  logic       prev_jump, prev_valid, prev_ready;
  logic [7:0] prev_instr;
  int         wait_cnt;
  exp_t       ne;

  initial begin
    rst2_n = 1'b0;
    // Program image without the halt opcode so the random run keeps going.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i][7:5] == 3'b111) mem[i][7] = 1'b0;
    end

    // ---------------- randomized phase ----------------
    do_reset();
    mon_en     = 1'b1;
    exp_addr   = 8'h00;
    prev_jump  = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_instr = 8'h00;
    wait_cnt   = 0;
    for (int it = 0; it < 3000; it++) begin
      step();
      // Consequences of the inputs driven in the previous cycle.
      if (prev_jump) begin
        check("jump_drops_valid", inst_valid, 0);
        check("jump_refetches", mem_req, 1);
      end else if (prev_valid && prev_ready) begin
        check("accept_refetches", mem_req, 1);
      end else if (prev_valid) begin
        check("stall_keeps_valid", inst_valid, 1);
        check("stall_keeps_instr", instruction, prev_instr);
      end
      check("req_excl_valid", mem_req & inst_valid, 0);
      check("not_halted", halted, 0);
      if (mem_req) check("mem_addr", mem_addr, exp_addr);

      // New stimulus for this cycle.
      jump_en    = ($urandom_range(0, 9) == 0);
      jump_addr  = 8'($urandom);
      inst_ready = ($urandom_range(0, 9) < 6);
      if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          wait_cnt = $urandom_range(0, 3);
        end else begin
          mem_ack  = 1'b0;
          mem_data = 8'($urandom);
          wait_cnt--;
        end
      end else begin
        mem_ack  = ($urandom_range(0, 4) == 0);  // stray acks must be ignored
        mem_data = 8'($urandom);
      end

      // Reference model of the fetch stream.
      if (mem_req && mem_ack && !jump_en) begin
        ne.data = mem[exp_addr];
        ne.pc   = exp_addr + 8'd1;
        ne.cyc  = cycle_cnt;
        sb_q.push_back(ne);
      end
      if (jump_en) exp_addr = jump_addr;
      else if (mem_req && mem_ack) exp_addr = exp_addr + 8'd1;

      prev_jump  = jump_en;
      prev_valid = inst_valid;
      prev_ready = inst_ready;
      prev_instr = instruction;
    end
    jump_en = 1'b0; mem_ack = 1'b0; inst_ready = 1'b1;
    repeat (3) step();
    check("sb_drained", sb_q.size(), 0);
    mon_en = 1'b0;

    // ---------------- directed phase ----------------
    do_reset();
    check("idle_no_req", mem_req, 0);
    mem_ack = 1'b1; mem_data = 8'h53; inst_ready = 1'b1;
    step();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 8'h00);
    step();
    check("d1_valid", inst_valid, 1);
    check("d1_instr", instruction, 8'h53);
    check("d1_pc", pc, 8'h01);
    mem_data = 8'h7F;
    step();
    check("d1_refetch_addr", mem_addr, 8'h01);
    step();
    check("d2_valid", inst_valid, 1);
    check("d2_instr", instruction, 8'h7F);
    check("d2_pc", pc, 8'h02);

    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", inst_valid, 1);
      check("stall_instr", instruction, 8'h7F);
      check("stall_no_req", mem_req, 0);
      check("stall_pc", pc, 8'h02);
    end

    jump_en = 1'b1; jump_addr = 8'h00; inst_ready = 1'b1; mem_data = 8'h53;
    step();
    check("jhold_valid", inst_valid, 0);
    check("jhold_addr", mem_addr, 8'h00);
    jump_en = 1'b0;
    step();
    check("d3_instr", instruction, 8'h53);
    check("d3_valid", inst_valid, 1);
    jump_en = 1'b1; jump_addr = 8'h40;
    step();
    check("j40_valid", inst_valid, 0);
    check("j40_req", mem_req, 1);
    check("j40_addr", mem_addr, 8'h40);
    jump_en = 1'b0; mem_data = 8'hE1;
    step();
    check("halt_instr", instruction, 8'hE1);
    check("halt_instr_pc", pc, 8'h41);
    step();
    check("halted", halted, 1);
    check("halt_no_req", mem_req, 0);
    check("halt_no_valid", inst_valid, 0);
    jump_en = 1'b1; jump_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_ignores_jump", pc, 8'h41);
      check("halt_stays", halted, 1);
      check("halt_req_low", mem_req, 0);
    end

    // Asynchronous reset while halted with a held byte.
    #2 rst_n = 1'b0;
    #1;
    check("async_halt_cleared", halted, 0);
    check("async_instr_cleared", instruction, 8'h00);
    check("async_pc_reset", pc, 8'h00);
    step();
    rst_n = 1'b1;
    jump_en = 1'b1; jump_addr = 8'h05; mem_ack = 1'b0;
    step();
    check("j5_req", mem_req, 1);
    check("j5_pc", pc, 8'h05);
    jump_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_req_low", mem_req, 0);
    check("async_pc", pc, 8'h00);
    check("async_addr", mem_addr, 8'h00);
    check("async_valid", inst_valid, 0);
    step();
    rst_n = 1'b1;

    // RESET_PC = 8'hFF wraps to 8'h00 on the first fetch.
    check("wrap_rst_pc", pc2, 8'hFF);
    check("wrap_rst_addr", mem_addr2, 8'hFF);
    rst2_n = 1'b1;
    step();
    check("wrap_req", mem_req2, 1);
    check("wrap_req_addr", mem_addr2, 8'hFF);
    step();
    check("wrap_pc", pc2, 8'h00);
    check("wrap_instr", instruction2, 8'h12);
    check("wrap_valid", inst_valid2, 1);
    check("wrap_not_halted", halted2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
